// File: rtl/adc_code_decimator.sv
// Block decimator for flash ADC codes: averages 2^LOG2_N samples, tracks min/max, and
// presents each result through a valid/ready output register with sticky overrun.
module adc_code_decimator #(
    parameter int CODE_W = 4,
    parameter int LOG2_N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [CODE_W-1:0]        code_in,
    input  logic                     code_vld,
    input  logic                     out_ready,
    output logic [CODE_W-1:0]        avg_out,
    output logic [CODE_W+LOG2_N-1:0] sum_out,
    output logic [CODE_W-1:0]        min_out,
    output logic [CODE_W-1:0]        max_out,
    output logic                     avg_vld,
    output logic                     overrun,
    output logic                     busy
);
    localparam int SW = CODE_W + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_N) - 1);
    // Half an LSB of the shifted result; zero when LOG2_N = 0 so avg equals sum.
    localparam logic [SW:0]   HALF     = (SW+1)'((1 << LOG2_N) >> 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]        state;
    logic [SW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic [CODE_W-1:0] run_min;
    logic [CODE_W-1:0] run_max;

    logic              live;
    logic [SW-1:0]     base_acc;
    logic [CW-1:0]     base_cnt;
    logic [CODE_W-1:0] base_min;
    logic [CODE_W-1:0] base_max;
    logic [SW-1:0]     sum_nxt;
    logic [CODE_W-1:0] min_nxt;
    logic [CODE_W-1:0] max_nxt;
    logic [CODE_W-1:0] avg_nxt;
    logic              last;
    logic              xfer;

    // A window only carries samples while in ACCUM; IDLE always presents an empty window.
    always_comb begin
        live     = (state == ACCUM);
        base_acc = live ? acc : '0;
        base_cnt = live ? cnt : '0;
        base_min = live ? run_min : '1;
        base_max = live ? run_max : '0;
        sum_nxt  = base_acc + SW'(code_in);
        min_nxt  = (code_in < base_min) ? code_in : base_min;
        max_nxt  = (code_in > base_max) ? code_in : base_max;
        avg_nxt  = CODE_W'(({1'b0, sum_nxt} + HALF) >> LOG2_N);
        last     = en & code_vld & ~clr & (base_cnt == LAST_CNT);
        xfer     = avg_vld & out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            run_min <= '1;
            run_max <= '0;
        end else begin
            state <= en ? ACCUM : IDLE;
            if (clr || !en || last) begin
                acc     <= '0;
                cnt     <= '0;
                run_min <= '1;
                run_max <= '0;
            end else if (code_vld) begin
                acc     <= sum_nxt;
                cnt     <= base_cnt + CW'(1);
                run_min <= min_nxt;
                run_max <= max_nxt;
            end
        end
    end

    // Output handshake: a result transfers on any cycle with avg_vld & out_ready; until then
    // avg_vld stays high and all result fields hold. A block finishing while a result is
    // pending and not transferring is dropped and raises overrun until clr or rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_out <= '0;
            sum_out <= '0;
            min_out <= '1;
            max_out <= '0;
            avg_vld <= 1'b0;
            overrun <= 1'b0;
        end else if (clr) begin
            avg_out <= '0;
            sum_out <= '0;
            min_out <= '1;
            max_out <= '0;
            avg_vld <= 1'b0;
            overrun <= 1'b0;
        end else if (last && (!avg_vld || xfer)) begin
            avg_out <= avg_nxt;
            sum_out <= sum_nxt;
            min_out <= min_nxt;
            max_out <= max_nxt;
            avg_vld <= 1'b1;
        end else if (last) begin
            overrun <= 1'b1;
        end else if (xfer) begin
            avg_vld <= 1'b0;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: tb/tb_adc_code_decimator.sv
// Bench for adc_code_decimator: three instances (LOG2_N = 4, 2, 3) share one stimulus and are
// checked every cycle against a sample-list model plus directed literal expectations.
module tb_adc_code_decimator;
    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] code_in;
    logic       code_vld;
    logic       out_ready;

    logic [3:0]  avg_o[3];
    logic [3:0]  min_o[3];
    logic [3:0]  max_o[3];
    logic        vld_o[3];
    logic        ovr_o[3];
    logic        busy_o[3];
    logic [11:0] sum_o[3];
    logic [7:0]  s4;
    logic [5:0]  s2;
    logic [6:0]  s3;

    int lg[3] = '{4, 2, 3};
    int n_cmp = 0;
    int n_fail = 0;

    adc_code_decimator #(.CODE_W(4), .LOG2_N(4)) u_l4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .code_in(code_in), .code_vld(code_vld),
        .out_ready(out_ready), .avg_out(avg_o[0]), .sum_out(s4), .min_out(min_o[0]),
        .max_out(max_o[0]), .avg_vld(vld_o[0]), .overrun(ovr_o[0]), .busy(busy_o[0]));
    adc_code_decimator #(.CODE_W(4), .LOG2_N(2)) u_l2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .code_in(code_in), .code_vld(code_vld),
        .out_ready(out_ready), .avg_out(avg_o[1]), .sum_out(s2), .min_out(min_o[1]),
        .max_out(max_o[1]), .avg_vld(vld_o[1]), .overrun(ovr_o[1]), .busy(busy_o[1]));
    adc_code_decimator #(.CODE_W(4), .LOG2_N(3)) u_l3 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .code_in(code_in), .code_vld(code_vld),
        .out_ready(out_ready), .avg_out(avg_o[2]), .sum_out(s3), .min_out(min_o[2]),
        .max_out(max_o[2]), .avg_vld(vld_o[2]), .overrun(ovr_o[2]), .busy(busy_o[2]));

    assign sum_o[0] = {4'b0, s4};
    assign sum_o[1] = {6'b0, s2};
    assign sum_o[2] = {5'b0, s3};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: the current window is a plain list of samples; a result is computed from the
    // whole list when it reaches N entries.
    int win[3][256];
    int m_n[3];
    int m_sum[3];
    int m_avg[3];
    int m_min[3];
    int m_max[3];
    bit m_vld[3];
    bit m_ovr[3];

    task automatic model_clear_out(input int i);
        m_sum[i] = 0;
        m_avg[i] = 0;
        m_min[i] = 15;
        m_max[i] = 0;
        m_vld[i] = 0;
        m_ovr[i] = 0;
    endtask

    task automatic model_edge();
        int n, s, mn, mx;
        bit xfer, done;
        for (int i = 0; i < 3; i++) begin
            n = 1 << lg[i];
            if (rst || clr) begin
                m_n[i] = 0;
                model_clear_out(i);
            end else begin
                xfer = m_vld[i] && out_ready;
                done = 0;
                if (!en) begin
                    m_n[i] = 0;
                end else if (code_vld) begin
                    win[i][m_n[i]] = int'(code_in);
                    m_n[i]++;
                    done = (m_n[i] == n);
                end
                if (done) begin
                    s = 0;
                    mn = 15;
                    mx = 0;
                    for (int k = 0; k < n; k++) begin
                        s += win[i][k];
                        if (win[i][k] < mn) mn = win[i][k];
                        if (win[i][k] > mx) mx = win[i][k];
                    end
                    m_n[i] = 0;
                    if (!m_vld[i] || xfer) begin
                        m_sum[i] = s;
                        m_avg[i] = (s + n / 2) / n;
                        m_min[i] = mn;
                        m_max[i] = mx;
                        m_vld[i] = 1;
                    end else begin
                        m_ovr[i] = 1;
                    end
                end else if (xfer) begin
                    m_vld[i] = 0;
                end
            end
        end
    endtask

    task automatic cmp(input string nm, input int i, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s L%0d at %0t: got %0d expected %0d", nm, lg[i], $time, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            cmp("model_avg", i, int'(avg_o[i]), m_avg[i]);
            cmp("model_sum", i, int'(sum_o[i]), m_sum[i]);
            cmp("model_min", i, int'(min_o[i]), m_min[i]);
            cmp("model_max", i, int'(max_o[i]), m_max[i]);
            cmp("model_vld", i, int'(vld_o[i]), int'(m_vld[i]));
            cmp("model_ovr", i, int'(ovr_o[i]), int'(m_ovr[i]));
            cmp("model_busy", i, int'(busy_o[i]), int'(m_n[i] != 0));
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic v, input logic [3:0] d,
                         input logic r);
        en = e;
        clr = c;
        code_vld = v;
        code_in = d;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic chk_result(input string nm, input int i, input int vld, input int sum,
                              input int avg, input int mn, input int mx);
        cmp({nm, "_vld"}, i, int'(vld_o[i]), vld);
        cmp({nm, "_sum"}, i, int'(sum_o[i]), sum);
        cmp({nm, "_avg"}, i, int'(avg_o[i]), avg);
        cmp({nm, "_min"}, i, int'(min_o[i]), mn);
        cmp({nm, "_max"}, i, int'(max_o[i]), mx);
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        code_vld = 1'b0;
        code_in = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0;
            model_clear_out(i);
        end
        fork
            forever begin
                @(posedge clk or posedge rst);
                model_edge();
                #1;
                compare_all();
            end
        join_none
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_result("reset", 0, 0, 0, 0, 15, 0);
        cmp("reset_ovr", 0, int'(ovr_o[0]), 0);
        cmp("reset_busy", 0, int'(busy_o[0]), 0);
        rst = 1'b0;

        // 16 samples of 7, consumer always ready
        for (int k = 0; k < 16; k++) drive(1, 0, 1, 4'd7, 1);
        chk_result("blk7", 0, 1, 112, 7, 7, 7);
        drive(1, 0, 0, 4'd0, 1);
        cmp("blk7_xfer_vld", 0, int'(vld_o[0]), 0);

        // round half up: 0,1,1,1 then full-scale block
        drive(1, 1, 0, 4'd0, 1);
        drive(1, 0, 1, 4'd0, 1);
        for (int k = 0; k < 3; k++) drive(1, 0, 1, 4'd1, 1);
        chk_result("round", 1, 1, 3, 1, 0, 1);
        for (int k = 0; k < 4; k++) drive(1, 0, 1, 4'd15, 1);
        chk_result("full", 1, 1, 60, 15, 15, 15);

        // overrun: two blocks with the consumer stalled, then clr
        drive(1, 1, 0, 4'd0, 0);
        for (int k = 0; k < 4; k++) drive(1, 0, 1, 4'd2, 0);
        chk_result("ovr_first", 1, 1, 8, 2, 2, 2);
        cmp("ovr_first_flag", 1, int'(ovr_o[1]), 0);
        for (int k = 0; k < 4; k++) drive(1, 0, 1, 4'd9, 0);
        chk_result("ovr_kept", 1, 1, 8, 2, 2, 2);
        cmp("ovr_set", 1, int'(ovr_o[1]), 1);
        drive(1, 1, 0, 4'd0, 0);
        cmp("clr_vld", 1, int'(vld_o[1]), 0);
        cmp("clr_ovr", 1, int'(ovr_o[1]), 0);

        // stalls between qualified samples
        drive(1, 0, 1, 4'd3, 1);
        cmp("stall_busy1", 1, int'(busy_o[1]), 1);
        for (int k = 0; k < 5; k++) drive(1, 0, k[0] ? 1'b1 : 1'b0, 4'd3, 1);
        cmp("stall_novld", 1, int'(vld_o[1]), 0);
        cmp("stall_busy3", 1, int'(busy_o[1]), 1);
        drive(1, 0, 1, 4'd3, 1);
        chk_result("stall", 1, 1, 12, 3, 3, 3);
        cmp("stall_busy_done", 1, int'(busy_o[1]), 0);

        // en dropped mid-block discards the partial window
        drive(1, 1, 0, 4'd0, 1);
        for (int k = 0; k < 5; k++) drive(1, 0, 1, 4'd1, 1);
        drive(0, 0, 0, 4'd0, 1);
        drive(0, 0, 0, 4'd0, 1);
        cmp("en_off_busy", 2, int'(busy_o[2]), 0);
        for (int k = 0; k < 7; k++) drive(1, 0, 1, 4'd4, 1);
        cmp("en_partial_novld", 2, int'(vld_o[2]), 0);
        drive(1, 0, 1, 4'd4, 1);
        chk_result("en_block", 2, 1, 32, 4, 4, 4);

        // asynchronous reset mid-block with a pending result
        drive(1, 1, 0, 4'd0, 0);
        for (int k = 0; k < 6; k++) drive(1, 0, 1, 4'd5, 0);
        cmp("pre_rst_vld", 1, int'(vld_o[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk_result("async_rst", 1, 0, 0, 0, 15, 0);
        cmp("async_rst_ovr", 1, int'(ovr_o[1]), 0);
        cmp("async_rst_busy", 1, int'(busy_o[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) drive(1, 0, 1, 4'd6, 1);
        cmp("post_rst_novld", 1, int'(vld_o[1]), 0);
        drive(1, 0, 1, 4'd6, 1);
        chk_result("post_rst", 1, 1, 24, 6, 6, 6);
        drive(1, 0, 0, 4'd0, 1);
        drive(1, 0, 0, 4'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_code_decimator.md
Name: adc_code_decimator

Overview:
- Downstream of the flash ADC thermometer-to-binary encoder.
- Consumes one registered 4-bit binary code per qualified cycle and averages blocks of 2^LOG2_N consecutive samples.
- Tracks the min and max code seen in each block.
- Presents each block result to the readout/serial stage through a valid/ready handshake, with overrun detection.

Parameters:
- CODE_W, 4: width of the input code and of the averaged output.
- LOG2_N, 4: log2 of the block length. Legal range 0..8; N = 2^LOG2_N samples per result.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- en  input  1  run enable; low forces IDLE
- clr  input  1  synchronous clear of the window, the output register and the overrun flag
- code_in  input  CODE_W  binary code from the encoder
- code_vld  input  1  code_in qualified this cycle
- out_ready  input  1  consumer accepts the result this cycle
- avg_out  output  CODE_W  rounded block average
- sum_out  output  CODE_W+LOG2_N  raw block sum
- min_out  output  CODE_W  minimum code in the block
- max_out  output  CODE_W  maximum code in the block
- avg_vld  output  1  result valid
- overrun  output  1  sticky: a completed block was dropped
- busy  output  1  window partially filled (cnt != 0)

Behaviour:
- Reset (async, rst high):
  - State IDLE; acc, cnt = 0.
  - avg_out, sum_out, max_out = 0; min_out = all ones.
  - avg_vld, overrun, busy = 0.
- States: IDLE, ACCUM. There is no output-holding state; the output register is independent of the window FSM.
- IDLE:
  - acc, cnt and running min/max are cleared; code_vld is ignored.
  - Goes to ACCUM on the first cycle with en=1. A code_vld in that same cycle is accumulated.
- ACCUM:
  - On each code_vld=1: acc += code_in, cnt += 1, running min/max updated.
  - Cycles with code_vld=0 are stalls with no state change.
- Block completion (code_vld=1 with cnt == N-1):
  - Next cycle the output register loads:
    - sum_out = acc + code_in
    - avg_out = (sum + 2^(LOG2_N-1)) >> LOG2_N, i.e. round half up. For LOG2_N=0, avg_out = sum.
    - min_out / max_out include the final sample.
  - avg_vld = 1.
  - Latency: 1 cycle from the last sample to avg_vld.
  - acc, cnt and running min/max restart in the same edge. The next code_vld begins the new block with no dead cycle.
- Arithmetic:
  - acc width is CODE_W+LOG2_N; it cannot overflow.
  - Rounded average never exceeds 2^CODE_W-1, so no saturation logic is required.
- Handshake:
  - A transfer occurs on a cycle with avg_vld & out_ready.
  - avg_vld stays high and all result outputs stay stable until the transfer.
  - The consumer may hold out_ready high continuously.
- Simultaneous events:
  - Block completes in the same cycle as a transfer: new result loads, avg_vld stays 1, no overrun.
  - Block completes while avg_vld=1 with no transfer: new result discarded, old result retained, overrun set to 1 and held until clr or rst.
- en deasserted mid-block:
  - Return to IDLE next cycle; the partial block is discarded.
  - A pending result (avg_vld=1) is retained until transferred.
  - Re-enabling starts a fresh block.
- clr (priority over all activity except rst):
  - acc, cnt = 0; avg_vld = 0; overrun = 0.
  - State becomes ACCUM if en=1, else IDLE.
  - A code_vld in the clr cycle is dropped.
- busy = (cnt != 0).

Test Plan:
- LOG2_N=4; 16 samples of code 7 with code_vld continuous, out_ready=1 -> one cycle after the 16th sample: avg_vld=1, sum_out=112, avg_out=7, min_out=7, max_out=7; transfer that cycle, avg_vld=0 next cycle.
- LOG2_N=2; codes 0,1,1,1 (sum 3) -> avg_out=1 (round half up of 0.75), sum_out=3, min_out=0, max_out=1. Then codes 15,15,15,15 -> avg_out=15, sum_out=60.
- LOG2_N=2, out_ready=0, two back-to-back blocks (2,2,2,2 then 9,9,9,9) -> avg_out stays 2, overrun=1 after the second block; clr -> avg_vld=0, overrun=0.
- LOG2_N=2; codes 3 with code_vld toggling 1,0,1,0,... -> result appears only after the 4th qualified sample; stall cycles change nothing; busy high from the first sample until completion.
- LOG2_N=3; 5 samples then en=0 for 2 cycles, then en=1 and 8 samples of 4 -> exactly one result, avg_out=4, sum_out=32 (partial block discarded).
- rst asserted mid-block with avg_vld=1 -> all outputs return to reset values asynchronously; the first block after reset completes after exactly N samples.
